// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage types: divide opcodes, divider FSM states and
// iteration constants used by the divide sequencer.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_CNT_W = 5;

    localparam logic [DIV_CNT_W-1:0] DIV_ITER_CNT = 5'd31;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
    import riscv_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic            dividend_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);

    // One extra bit so the borrow of the trial subtraction is never lost.
    logic [XLEN+1:0] trial;

    always_comb begin
        trial   = {rem_i, dividend_msb_i} - {2'b00, divisor_i};
        q_bit_o = ~trial[XLEN+1];
        rem_o   = q_bit_o ? trial[XLEN:0] : {rem_i[XLEN-1:0], dividend_msb_i};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: 32-step restoring division with
// one-cycle special cases, a single-entry result cache and flush abort.
module div_sequencer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            req_valid,
    input  div_op_e         req_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            req_ready,
    output logic            busy,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output div_state_e      dbg_state
);

    // Handshake: req_valid is a level held with stable operands until the
    // one-cycle resp_valid strobe; a request is taken only when req_ready
    // (IDLE) and flush is low, and resp_valid is never raised with flush.

    div_state_e state_q, state_d;

    div_op_e               op_q, op_d;
    logic                  signed_q, signed_d;
    logic [XLEN-1:0]       a_q, a_d;
    logic [XLEN-1:0]       b_q, b_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       dvsr_q, dvsr_d;
    logic [XLEN:0]         rem_q, rem_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]       resp_data_q, resp_data_d;

    logic                  c_valid_q, c_valid_d;
    logic [XLEN-1:0]       c_a_q, c_a_d;
    logic [XLEN-1:0]       c_b_q, c_b_d;
    logic                  c_signed_q, c_signed_d;
    logic [XLEN-1:0]       c_quo_q, c_quo_d;
    logic [XLEN-1:0]       c_rem_q, c_rem_d;

    logic            req_signed;
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic            cache_hit;
    logic            special;
    logic [XLEN-1:0] spec_quo;
    logic [XLEN-1:0] spec_rem;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN:0]   step_rem;
    logic            step_q_bit;

    div_step u_step (
        .rem_i          (rem_q),
        .dividend_msb_i (quo_q[XLEN-1]),
        .divisor_i      (dvsr_q),
        .rem_o          (step_rem),
        .q_bit_o        (step_q_bit)
    );

    // Request decode: special cases resolve in the accept cycle.
    always_comb begin
        req_signed = is_signed_op(req_op);
        accept     = (state_q == IDLE) && req_valid && !flush;
        div_zero   = (op_b == '0);
        overflow   = req_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        cache_hit  = c_valid_q && (c_a_q == op_a) && (c_b_q == op_b)
                     && (c_signed_q == req_signed);
        special    = div_zero || overflow || cache_hit;

        if (div_zero) begin
            spec_quo = 32'hFFFF_FFFF;
            spec_rem = op_a;
        end else if (overflow) begin
            spec_quo = 32'h8000_0000;
            spec_rem = '0;
        end else begin
            spec_quo = c_quo_q;
            spec_rem = c_rem_q;
        end

        a_abs = (req_signed && op_a[XLEN-1]) ? (32'd0 - op_a) : op_a;
        b_abs = (req_signed && op_b[XLEN-1]) ? (32'd0 - op_b) : op_b;

        fix_quo = (signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? (32'd0 - quo_q) : quo_q;
        fix_rem = (signed_q && a_q[XLEN-1]) ? (32'd0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : ITER;
            ITER:    if (cnt_q == '0) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        resp_valid = (state_q == DONE) && !flush;
        resp_data  = resp_data_q;
        dbg_state  = state_q;
    end

    always_comb begin
        op_d        = op_q;
        signed_d    = signed_q;
        a_d         = a_q;
        b_d         = b_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        c_valid_d   = c_valid_q;
        c_a_d       = c_a_q;
        c_b_d       = c_b_q;
        c_signed_d  = c_signed_q;
        c_quo_d     = c_quo_q;
        c_rem_d     = c_rem_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = req_op;
                    signed_d = req_signed;
                    a_d      = op_a;
                    b_d      = op_b;
                    if (special) begin
                        resp_data_d = is_rem_op(req_op) ? spec_rem : spec_quo;
                    end else begin
                        quo_d  = a_abs;
                        dvsr_d = b_abs;
                        rem_d  = '0;
                        cnt_d  = DIV_ITER_CNT;
                    end
                end
            end
            ITER: begin
                // The dividend register fills with quotient bits from the right.
                quo_d = {quo_q[XLEN-2:0], step_q_bit};
                rem_d = step_rem;
                cnt_d = cnt_q - 5'd1;
            end
            FIXUP: begin
                if (!flush) begin
                    resp_data_d = is_rem_op(op_q) ? fix_rem : fix_quo;
                    c_valid_d   = 1'b1;
                    c_a_d       = a_q;
                    c_b_d       = b_q;
                    c_signed_d  = signed_q;
                    c_quo_d     = fix_quo;
                    c_rem_d     = fix_rem;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= DIV;
            signed_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            c_valid_q   <= 1'b0;
            c_a_q       <= '0;
            c_b_q       <= '0;
            c_signed_q  <= 1'b0;
            c_quo_q     <= '0;
            c_rem_q     <= '0;
        end else begin
            op_q        <= op_d;
            signed_q    <= signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            c_valid_q   <= c_valid_d;
            c_a_q       <= c_a_d;
            c_b_q       <= c_b_d;
            c_signed_q  <= c_signed_d;
            c_quo_q     <= c_quo_d;
            c_rem_q     <= c_rem_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed corner cases plus random requests checked
// by a scoreboard against an arithmetic reference with a modelled result cache.
module tb_div_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        req_valid;
    div_op_e     req_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        req_ready;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    div_state_e  dbg_state;

    div_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .req_ready  (req_ready),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 data %h expected no response", resp_data);
            end else begin
                logic [31:0] e;
                int          acc;
                int          lat;
                e   = exp_q.pop_front();
                acc = acc_q.pop_front();
                lat = lat_q.pop_front();
                check("resp_data", resp_data, e);
                check("resp_latency", 32'(cyc - acc), 32'(lat));
            end
        end
    end

    // ---------------- reference model ----------------
    logic        cm_valid;
    logic [31:0] cm_a, cm_b;
    logic        cm_s;

    function automatic bit ref_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic bit ref_special(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (ref_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic bit ref_hit(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        return cm_valid && cm_a == a && cm_b == b && cm_s == ref_signed(op);
    endfunction

    function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        longint      sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (ref_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (ref_signed(op)) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == REM || op == REMU) ? r : q;
    endfunction

    function automatic int ref_latency(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        return (ref_special(op, a, b) || ref_hit(op, a, b)) ? 1 : 34;
    endfunction

    task automatic cache_fill(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        if (!ref_special(op, a, b) && !ref_hit(op, a, b)) begin
            cm_valid = 1'b1;
            cm_a     = a;
            cm_b     = b;
            cm_s     = ref_signed(op);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) return;
        end
        check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drive_req(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
    endtask

    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        bit got;
        wait_ready();
        drive_req(op, a, b);
        exp_q.push_back(ref_result(op, a, b));
        acc_q.push_back(cyc);
        lat_q.push_back(ref_latency(op, a, b));
        cache_fill(op, a, b);
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) got = 1;
        end
        if (!got) begin
            check("resp_timeout", 32'(resp_valid), 32'd1);
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end
        req_valid = 1'b0;
    endtask

    // Start a request, then at cycle 'at' after acceptance hit it with flush
    // (use_reset=0) or an asynchronous reset (use_reset=1).
    task automatic issue_abort(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input int at, input bit use_reset);
        wait_ready();
        drive_req(op, a, b);
        repeat (at) @(negedge clk);
        if (use_reset) begin
            reset_n = 1'b0;
            #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_resp_data", resp_data, 32'd0);
            cm_valid = 1'b0;
            @(negedge clk);
            reset_n   = 1'b1;
            req_valid = 1'b0;
        end else begin
            flush = 1'b1;
            #1;
            check("flush_resp_valid", 32'(resp_valid), 32'd0);
            if (at >= 34) cache_fill(op, a, b);
            @(negedge clk);
            flush     = 1'b0;
            req_valid = 1'b0;
            check("flush_ready", 32'(req_ready), 32'd1);
            check("flush_busy", 32'(busy), 32'd0);
            check("flush_state", 32'(dbg_state), 32'(IDLE));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pool[8];
        div_op_e     op;
        logic [31:0] a, b;

        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = DIV;
        op_a      = '0;
        op_b      = '0;
        cm_valid  = 1'b0;
        cm_a      = '0;
        cm_b      = '0;
        cm_s      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;

        issue(DIVU, 32'd100, 32'd7);
        issue(REMU, 32'd100, 32'd7);
        issue(DIV,  32'hFFFF_FFF9, 32'd2);
        issue(REM,  32'hFFFF_FFF9, 32'd2);
        issue(DIVU, 32'hFFFF_FFF9, 32'd2);
        issue(DIVU, 32'd5, 32'd0);
        issue(REM,  32'd5, 32'd0);
        issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        issue(REM,  32'h8000_0000, 32'hFFFF_FFFF);

        issue_abort(DIVU, 32'd12345, 32'd67, 10, 1'b0);
        issue(DIVU, 32'd1000, 32'd10);

        issue_abort(DIVU, 32'd5, 32'd0, 1, 1'b0);
        issue_abort(REMU, 32'd999, 32'd37, 34, 1'b0);
        issue(DIVU, 32'd999, 32'd37);

        issue(DIVU, 32'd77777, 32'd13);
        issue_abort(DIV, 32'd4242, 32'd17, 5, 1'b1);
        issue(DIVU, 32'd77777, 32'd13);

        pool[0] = 32'h8000_0000;
        pool[1] = 32'hFFFF_FFFF;
        pool[2] = 32'd1;
        pool[3] = 32'd3;
        pool[4] = 32'h7FFF_FFFF;
        pool[5] = 32'hFFFF_FF00;
        pool[6] = 32'd1000;
        pool[7] = 32'd0;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            op = div_op_e'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                a = ($urandom_range(0, 1) == 0) ? $urandom : pool[$urandom_range(0, 7)];
                b = ($urandom_range(0, 1) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            end
            issue(op, a, b);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the integer divide datapath used by the execute stage for DIV/DIVU/REM/REMU. It accepts one request at a time from EX and runs a 32-step restoring division. It resolves divide-by-zero, signed overflow and repeated-operand cases in one cycle, and returns a single-cycle response pulse that EX uses to release its stall. Flush from the pipeline controller aborts any operation in flight.

## Interface
Parameters:
- none (data width fixed at 32, per RV32M)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  abort current operation (pipeline flush of EX)
- req_valid  in  1  EX holds a divide instruction; level, held with operands stable until resp_valid
- req_op  in  div_op_e (2)  DIV, DIVU, REM, REMU
- op_a  in  32  dividend (rs1)
- op_b  in  32  divisor (rs2)
- req_ready  out  1  sequencer is idle and can accept a request; reset 1
- busy  out  1  operation in flight (state != IDLE); reset 0
- resp_valid  out  1  one-cycle result strobe; reset 0
- resp_data  out  32  quotient or remainder per req_op; valid only with resp_valid; reset 0

## Operation
- FSM states: IDLE, ITER, FIXUP, DONE. Reset state is IDLE.
- IDLE & req_valid & ~flush: the request is accepted. Latch req_op and signedness (DIV/REM signed).
  - Special case, next state DONE:
    - op_b==0: quotient = 0xFFFFFFFF, remainder = op_a.
    - Signed, op_a==0x80000000, op_b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
    - Cache hit (below): stored result.
  - Otherwise, next state ITER. Load |op_a| and |op_b| (absolute value only when signed), clear the 33-bit partial remainder, set count to 31.
- ITER, one quotient bit per cycle:
  - Shift {rem, dividend} left 1.
  - Trial = rem - divisor (33-bit).
  - If trial is non-negative: rem = trial, q bit = 1. Else q bit = 0.
  - Count decrements. At count==0, next state is FIXUP.
- FIXUP:
  - Negate the quotient if signed and op_a[31]^op_b[31].
  - Negate the remainder if signed and op_a[31].
  - Write the result cache. Next state DONE.
- DONE: resp_valid = ~flush. resp_data = quotient for DIV/DIVU, remainder for REM/REMU. Next state is always IDLE, regardless of req_valid.
- Result cache: one entry {valid, op_a, op_b, signed, quotient, remainder}.
  - Written only in FIXUP, i.e. only by normal completions.
  - Hit = valid & op_a/op_b/signed match. The op may differ (DIV followed by REM is a hit).
  - Reset clears valid. Flush does not clear it.
- flush in any state: next state IDLE, no resp_valid, datapath registers don't-care, cache unchanged.
- flush and req_valid in the same IDLE cycle: the request is not accepted.
- Reset asserted mid-operation: immediate return to IDLE, all outputs at reset values, cache invalid.

## Timing
- Accept cycle = cycle 0 (IDLE, req_valid sampled high).
- Normal path:
  - ITER occupies cycles 1–32.
  - FIXUP is cycle 33.
  - resp_valid is asserted in cycle 34.
  - req_ready returns high in cycle 35.
- Special or cache-hit path: resp_valid in cycle 1, req_ready in cycle 2.
- EX stall = req_valid & ~resp_valid. EX advances on the resp_valid cycle, so the next req_valid seen in IDLE belongs to a new instruction.
- Back-to-back throughput: normal 35 cycles per op; special or hit 2 cycles per op.
- req_ready and busy are combinational from state. resp_valid is combinational from state and flush. resp_data is registered.

## Structure
- riscv_pkg gains:
  - div_op_e (DIV, DIVU, REM, REMU).
  - div_state_e (IDLE, ITER, FIXUP, DONE).
  - DIV_ITER_CNT = 31.
- One combinational sub-module, div_step: one restoring step. Inputs are the 33-bit rem, the dividend MSB and the 32-bit divisor. Outputs are next rem and the q bit. The sequencer owns all state, counters, sign fixup and the cache.
- 5-bit iteration counter. Operand, quotient and remainder registers in the sequencer.

## Test plan
- DIVU 100/7 → resp_valid at cycle 34, resp_data 14. Immediately after, REMU 100/7 → cache hit, resp_data 2 at cycle 1.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3) at cycle 34. REM with the same operands → 0xFFFFFFFF (−1) at cycle 1. DIVU with the same operands → signedness mismatch, full 34 cycles, 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF at cycle 1. REM 5/0 → 5 at cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- flush at cycle 10 of an ITER sequence → IDLE next cycle, resp_valid never asserted, req_ready high. A following DIVU 1000/10 returns 100 at cycle 34.
- flush coincident with DONE → resp_valid stays 0.
- reset_n low during ITER → IDLE, busy 0, resp_data 0, cache invalid. A repeat of the prior operands takes the full 34 cycles.
